cpub_bus_master: RTL and testbench

CPUB_BUS_MASTER -- requirements
Module: cpub_bus_master

---
 rtl/cpub_pkg.sv | 16 +
 rtl/cpub_irq_sync.sv | 26 ++
 rtl/cpub_bus_master.sv | 142 ++++++++++++++
 tb/tb_cpub_bus_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpub_pkg.sv
// Shared request payload and read/write encoding for the CPU-B bus master.
package cpub_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cpub_req_t;

endpackage

// File: rtl/cpub_irq_sync.sv
// Two-flop synchronizer for the active-low IRQ line plus a sticky pending flag.
// Synchronous active-low reset; set dominates clear.
module cpub_irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_n,
  input  logic clr,
  output logic pend
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      pend    <= 1'b0;
    end else begin
      sync1_q <= irq_n;
      sync2_q <= sync1_q;
      pend    <= !sync2_q || (pend && !clr);
    end
  end

endmodule

// File: rtl/cpub_bus_master.sv
// CPU-B bus master: free-running E clock and one multiplexed bus cycle per E period.
// Define CPUB_BUS_MASTER_IRQ_EN to build the synchronized IRQ pending latch.
module cpub_bus_master
  import cpub_pkg::*;
#(
  parameter int unsigned E_HALF = 3
) (
  input  logic              XTAL_IN,
  input  logic              RESET_IN,
  output logic              E_OUT,
  output logic              AS_OUT,
  output logic              RW_OUT,
  output logic [7:0]        A_HI_OUT,
  output logic [DATA_W-1:0] AL_OUT,
  input  logic [DATA_W-1:0] AL_IN,
  output logic              AL_IOM,
  input  logic              REQ_VALID_IN,
  output logic              REQ_READY_OUT,
  input  logic              REQ_RW_IN,
  input  logic [ADDR_W-1:0] REQ_ADDR_IN,
  input  logic [DATA_W-1:0] REQ_WDATA_IN,
  output logic              RSP_VALID_OUT,
  output logic [DATA_W-1:0] RSP_RDATA_OUT,
  input  logic              IRQ_IN,
  input  logic              IRQ_CLR_IN,
  output logic              IRQ_PEND_OUT
);

  localparam int unsigned       CNT_W     = 5;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(2 * E_HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_EHI   = CNT_W'(E_HALF);
  localparam logic [CNT_W-1:0]  CNT_ASEND = CNT_W'(E_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  cpub_req_t        hold_q, hold_d, act_q, act_d, in_req;
  logic             hold_vld_q, hold_vld_d, act_vld_q, act_vld_d;
  logic             wrap, accept, lo_half;
  logic             e_d, as_d, rw_d, iom_d, ready_d, rsp_vld_d;
  logic [7:0]       a_hi_d;
  logic [DATA_W-1:0] al_d, rdata_d;

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    wrap         = (cnt_q == CNT_LAST);
    accept       = REQ_VALID_IN && REQ_READY_OUT;
    in_req.rw    = REQ_RW_IN;
    in_req.addr  = REQ_ADDR_IN;
    in_req.wdata = REQ_WDATA_IN;
    cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    act_d        = act_q;
    act_vld_d    = act_vld_q;

    // Period boundary: held request wins, else a same-edge request goes straight to active.
    if (wrap) begin
      hold_vld_d = 1'b0;
      if (hold_vld_q) begin
        act_d     = hold_q;
        act_vld_d = 1'b1;
      end else if (accept) begin
        act_d     = in_req;
        act_vld_d = 1'b1;
      end else begin
        act_vld_d = 1'b0;
      end
    end else if (accept) begin
      hold_d     = in_req;
      hold_vld_d = 1'b1;
    end

    lo_half = (cnt_d < CNT_EHI);
    e_d     = !lo_half;
    as_d    = act_vld_d && (cnt_d < CNT_ASEND);
    rw_d    = act_vld_d ? act_d.rw : RW_READ;
    a_hi_d  = act_vld_d ? act_d.addr[15:8] : A_HI_OUT;
    al_d    = AL_OUT;
    iom_d   = 1'b0;
    if (act_vld_d) begin
      if (lo_half) begin
        al_d  = act_d.addr[7:0];
        iom_d = 1'b1;
      end else if (act_d.rw == RW_WRITE) begin
        al_d  = act_d.wdata;
        iom_d = 1'b1;
      end
    end

    ready_d   = !hold_vld_d;
    rsp_vld_d = wrap && act_vld_q && (act_q.rw == RW_READ);
    rdata_d   = rsp_vld_d ? AL_IN : RSP_RDATA_OUT;
  end

  always_ff @(posedge XTAL_IN) begin
    if (!RESET_IN) begin
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      act_q         <= '0;
      act_vld_q     <= 1'b0;
      E_OUT         <= 1'b0;
      AS_OUT        <= 1'b0;
      RW_OUT        <= RW_READ;
      A_HI_OUT      <= '0;
      AL_OUT        <= '0;
      AL_IOM        <= 1'b0;
      REQ_READY_OUT <= 1'b0;
      RSP_VALID_OUT <= 1'b0;
      RSP_RDATA_OUT <= '0;
    end else begin
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      act_q         <= act_d;
      act_vld_q     <= act_vld_d;
      E_OUT         <= e_d;
      AS_OUT        <= as_d;
      RW_OUT        <= rw_d;
      A_HI_OUT      <= a_hi_d;
      AL_OUT        <= al_d;
      AL_IOM        <= iom_d;
      REQ_READY_OUT <= ready_d;
      RSP_VALID_OUT <= rsp_vld_d;
      RSP_RDATA_OUT <= rdata_d;
    end
  end

`ifdef CPUB_BUS_MASTER_IRQ_EN
  cpub_irq_sync u_irq_sync (
    .clk   (XTAL_IN),
    .rst_n (RESET_IN),
    .irq_n (IRQ_IN),
    .clr   (IRQ_CLR_IN),
    .pend  (IRQ_PEND_OUT)
  );
`else
  logic irq_unused;
  assign irq_unused   = IRQ_IN ^ IRQ_CLR_IN;
  assign IRQ_PEND_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_cpub_bus_master.sv
// Scoreboard bench for cpub_bus_master: random requests against a period-slot reference model,
// plus reset-abandon, E_HALF=2 and IRQ sequences.
module tb_cpub_bus_master;

  localparam int EH  = 3;
  localparam int P   = 2 * EH;
  localparam int EH2 = 2;
  localparam int P2  = 2 * EH2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_n, irq_clr;
  logic        req_valid, req_rw, req2_valid, req2_rw;
  logic [15:0] req_addr, req2_addr;
  logic [7:0]  req_wdata, req2_wdata, al_in, al_in2;
  logic        e_o, as_o, rw_o, iom_o, ready, rsp_valid, pend;
  logic [7:0]  a_hi, al_out, rsp_rdata;
  logic        e2, as2, rw2, iom2, ready2, rsp_valid2, pend2;
  logic [7:0]  a_hi2, al2, rsp_rdata2;

  cpub_bus_master #(.E_HALF(EH)) u_dut (
    .XTAL_IN(clk), .RESET_IN(rst_n), .E_OUT(e_o), .AS_OUT(as_o), .RW_OUT(rw_o),
    .A_HI_OUT(a_hi), .AL_OUT(al_out), .AL_IN(al_in), .AL_IOM(iom_o),
    .REQ_VALID_IN(req_valid), .REQ_READY_OUT(ready), .REQ_RW_IN(req_rw),
    .REQ_ADDR_IN(req_addr), .REQ_WDATA_IN(req_wdata), .RSP_VALID_OUT(rsp_valid),
    .RSP_RDATA_OUT(rsp_rdata), .IRQ_IN(irq_n), .IRQ_CLR_IN(irq_clr), .IRQ_PEND_OUT(pend)
  );

  cpub_bus_master #(.E_HALF(EH2)) u_dut2 (
    .XTAL_IN(clk), .RESET_IN(rst_n), .E_OUT(e2), .AS_OUT(as2), .RW_OUT(rw2),
    .A_HI_OUT(a_hi2), .AL_OUT(al2), .AL_IN(al_in2), .AL_IOM(iom2),
    .REQ_VALID_IN(req2_valid), .REQ_READY_OUT(ready2), .REQ_RW_IN(req2_rw),
    .REQ_ADDR_IN(req2_addr), .REQ_WDATA_IN(req2_wdata), .RSP_VALID_OUT(rsp_valid2),
    .RSP_RDATA_OUT(rsp_rdata2), .IRQ_IN(irq_n), .IRQ_CLR_IN(irq_clr), .IRQ_PEND_OUT(pend2)
  );

  typedef struct { bit rw; bit [15:0] addr; bit [7:0] wd; bit [7:0] rd; } slot_t;
  typedef struct { int cyc; bit [7:0] d; } rsp_t;

  slot_t     slots [int];
  rsp_t      rsp_q [$];
  slot_t     cur, nw;
  rsp_t      rsp_front;
  int        cyc = 0;
  int        last_start = -100;
  int        nb, st, ph, ps;
  bit        rst_q = 1'b1;
  bit [7:0]  exp_ahi, exp_al, exp_rd, nxt_rdata;
  int        n_chk = 0;
  int        n_fail = 0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: each accepted request owns the first free E period after acceptance.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      rst_q = 1'b1; cyc = 0; last_start = -100;
      slots.delete(); rsp_q.delete();
      exp_ahi = 8'h00; exp_al = 8'h00; exp_rd = 8'h00;
    end else begin
      rst_q = 1'b0;
      if (req_valid && ready) begin
        nb = cyc - (cyc % P) + P;
        st = (nb > last_start + P) ? nb : last_start + P;
        nw.rw = req_rw; nw.addr = req_addr; nw.wd = req_wdata; nw.rd = nxt_rdata;
        slots[st] = nw;
        last_start = st;
        if (nw.rw) rsp_q.push_back('{st + P, nxt_rdata});
      end
      cyc++;
    end
  end

  // Monitor: bus pins and response port checked mid-cycle, then the responder drives AL_IN.
  initial forever begin
    @(negedge clk);
    if (rst_q) begin
      chk("rst_e", 32'(e_o), 32'(0));         chk("rst_as", 32'(as_o), 32'(0));
      chk("rst_rw", 32'(rw_o), 32'(1));       chk("rst_iom", 32'(iom_o), 32'(0));
      chk("rst_al", 32'(al_out), 32'(0));     chk("rst_a_hi", 32'(a_hi), 32'(0));
      chk("rst_ready", 32'(ready), 32'(0));   chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(0)); chk("rst_pend", 32'(pend), 32'(0));
      chk("rst_e2", 32'(e2), 32'(0));         chk("rst_ready2", 32'(ready2), 32'(0));
    end else begin
      ph = cyc % P;
      ps = cyc - ph;
      chk("e_clock", 32'(e_o), 32'(ph >= EH));
      chk("ready", 32'(ready), 32'(!(last_start > cyc)));
      if (slots.exists(ps)) begin
        cur = slots[ps];
        chk("as", 32'(as_o), 32'(ph < EH - 1));
        chk("rw", 32'(rw_o), 32'(cur.rw));
        chk("a_hi", 32'(a_hi), 32'(cur.addr[15:8]));
        exp_ahi = cur.addr[15:8];
        if (ph < EH) begin
          chk("iom_addr", 32'(iom_o), 32'(1));
          chk("al_addr", 32'(al_out), 32'(cur.addr[7:0]));
          exp_al = cur.addr[7:0];
        end else if (!cur.rw) begin
          chk("iom_wdata", 32'(iom_o), 32'(1));
          chk("al_wdata", 32'(al_out), 32'(cur.wd));
          exp_al = cur.wd;
        end else begin
          chk("iom_read", 32'(iom_o), 32'(0));
        end
      end else begin
        chk("idle_as", 32'(as_o), 32'(0));
        chk("idle_rw", 32'(rw_o), 32'(1));
        chk("idle_iom", 32'(iom_o), 32'(0));
        chk("idle_a_hi", 32'(a_hi), 32'(exp_ahi));
        chk("idle_al", 32'(al_out), 32'(exp_al));
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_spurious", 32'(rsp_valid), 32'(0));
        end else begin
          rsp_front = rsp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(rsp_front.cyc));
          chk("rsp_data", 32'(rsp_rdata), 32'(rsp_front.d));
          exp_rd = rsp_front.d;
        end
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
          chk("rsp_missing", 32'(rsp_valid), 32'(1));
          void'(rsp_q.pop_front());
        end
        chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(exp_rd));
      end
`ifndef CPUB_BUS_MASTER_IRQ_EN
      chk("irq_pend_tied", 32'(pend), 32'(0));
      chk("irq_pend2_tied", 32'(pend2), 32'(0));
`endif
    end
    // Only the final cycle of a read carries the real byte; anything else is noise.
    if (slots.exists(cyc - (cyc % P)) && slots[cyc - (cyc % P)].rw && (cyc % P) == P - 1)
      al_in = slots[cyc - (cyc % P)].rd;
    else
      al_in = 8'($urandom);
`ifndef CPUB_BUS_MASTER_IRQ_EN
    irq_n   = 1'($urandom);
    irq_clr = 1'($urandom);
`endif
  end

  task automatic issue(input bit rw, input bit [15:0] a, input bit [7:0] wd, input bit [7:0] rd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd; nxt_rdata = rd;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) chk("req_accept_timeout", 32'(ready), 32'(1));
  endtask

  task automatic quiet(input int k);
    @(negedge clk);
    req_valid = 1'b0; req_rw = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st2, ph2;
    bit in2;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b1; req_addr = 16'h0; req_wdata = 8'h0;
    req2_valid = 1'b0; req2_rw = 1'b1; req2_addr = 16'h0; req2_wdata = 8'h0;
    al_in = 8'h0; al_in2 = 8'h0; irq_n = 1'b1; irq_clr = 1'b0; nxt_rdata = 8'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet(4);

    issue(1'b0, 16'h1234, 8'hA5, 8'h00);
    quiet(2 * P);
    issue(1'b1, 16'h00C7, 8'h00, 8'h5A);
    quiet(2 * P);
    issue(1'b0, 16'h2001, 8'h11, 8'h00);
    issue(1'b1, 16'h2002, 8'h00, 8'h22);
    issue(1'b0, 16'h2003, 8'h33, 8'h00);
    quiet(3 * P);

    repeat (150) begin
      issue(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) quiet($urandom_range(0, 9));
    end
    quiet(3 * P);

    // Reset in the middle of an active read while a second request waits in holding.
    issue(1'b1, 16'h4321, 8'h00, 8'hEE);
    issue(1'b0, 16'h8765, 8'h99, 8'h00);
    quiet(0);
    n = 0;
    while (cyc != last_start - P + 4 && n < 4 * P) begin
      @(negedge clk);
      n++;
    end
    chk("reset_align", 32'(cyc), 32'(last_start - P + 4));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet(3);
    issue(1'b1, 16'h0F0F, 8'h00, 8'hC3);
    quiet(3 * P);

    // E_HALF=2 instance: single read, every pin traced through one period and its response.
    @(negedge clk);
    req2_valid = 1'b1; req2_rw = 1'b1; req2_addr = 16'hBE3C; req2_wdata = 8'h00;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!ready2 && n < 20);
    chk("dut2_accept", 32'(ready2), 32'(1));
    @(negedge clk);
    req2_valid = 1'b0;
    st2 = cyc;
    while (st2 % P2 != 0) st2++;
    for (int k = 0; k < 12 && cyc <= st2 + P2; k++) begin
      ph2 = cyc % P2;
      in2 = (cyc >= st2) && (cyc < st2 + P2);
      chk("e2", 32'(e2), 32'(ph2 >= EH2));
      chk("as2", 32'(as2), 32'(in2 && ph2 == 0));
      chk("iom2", 32'(iom2), 32'(in2 && ph2 < EH2));
      chk("rw2", 32'(rw2), 32'(1));
      if (in2) chk("a_hi2", 32'(a_hi2), 32'(8'hBE));
      if (in2 && ph2 < EH2) chk("al2", 32'(al2), 32'(8'h3C));
      chk("rsp_valid2", 32'(rsp_valid2), 32'(cyc == st2 + P2));
      if (cyc == st2 + P2) chk("rsp_rdata2", 32'(rsp_rdata2), 32'(8'h77));
      al_in2 = (in2 && ph2 == P2 - 1) ? 8'h77 : 8'($urandom);
      @(negedge clk);
    end

`ifdef CPUB_BUS_MASTER_IRQ_EN
    irq_n = 1'b0; irq_clr = 1'b0;
    @(negedge clk);
    irq_n = 1'b1;
    n = 0;
    while (!pend && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("irq_pend_set", 32'(pend), 32'(1));
    chk("irq_latency", 32'(n), 32'(2));
    chk("irq_pend2_set", 32'(pend2), 32'(1));
    irq_n = 1'b0;
    repeat (4) @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irq_set_beats_clr", 32'(pend), 32'(1));
    irq_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("irq_sticky", 32'(pend), 32'(1));
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(pend), 32'(0));
`endif

    quiet(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
